// File: rtl/huffman_seq.sv
// huffman_seq
//
// Frame sequencer for the 6-symbol Huffman core. For each accepted start it
// resets the core, streams one NPIX-pixel frame from a synchronous image ROM
// into the core, then waits for the core's count and code results and latches
// the CNT, HC and M tables. Between frames the core is held in reset, because
// it has no other way to restart.
//
// Ports
//   clk, reset            clock; asynchronous active-high reset
//   start                 one-cycle frame request, honoured only in IDLE
//   busy                  high in every state except IDLE
//   done                  one-cycle end-of-frame pulse (also on error ends)
//   err[1:0]              sticky status: 0 ok, 1 illegal pixel,
//                         2 CNT timeout, 3 CODE timeout
//   rom_rd, rom_addr      ROM read strobe and address
//   rom_q                 ROM data, valid the cycle after rom_rd
//   core_rst              active-high reset to the core
//   gray_valid, gray_data pixel strobe and value to the core
//   CNT_valid             core count-ready pulse
//   code_valid            core code-ready level
//   cnt_in, hc_in, m_in   core result buses, symbol 1 in [7:0] .. symbol 6 in [47:40]
//   cnt_tbl, hc_tbl, m_tbl latched result tables, same packing
//
// States
//   state        | meaning
//   -------------+--------------------------------------------------------
//   S_IDLE       | waiting for start; core held in reset
//   S_CLR        | two cycles of core reset before streaming
//   S_FETCH      | one ROM read per cycle, addresses 0..NPIX-1
//   S_WAIT_CNT   | last pixel drains; waiting for CNT_valid or timeout
//   S_WAIT_CODE  | waiting for code_valid or timeout
//   S_DONE       | done pulse after a successful frame
//   S_ERR        | done pulse after a failed frame; core held in reset

module huffman_seq #(
    parameter int NPIX    = 100,
    parameter int AW      = 7,
    parameter int TIMEOUT = 255
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          start,
    output logic          busy,
    output logic          done,
    output logic [1:0]    err,
    output logic          rom_rd,
    output logic [AW-1:0] rom_addr,
    input  logic [7:0]    rom_q,
    output logic          core_rst,
    output logic          gray_valid,
    output logic [7:0]    gray_data,
    input  logic          CNT_valid,
    input  logic          code_valid,
    input  logic [47:0]   cnt_in,
    input  logic [47:0]   hc_in,
    input  logic [47:0]   m_in,
    output logic [47:0]   cnt_tbl,
    output logic [47:0]   hc_tbl,
    output logic [47:0]   m_tbl
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_CLR,
        S_FETCH,
        S_WAIT_CNT,
        S_WAIT_CODE,
        S_DONE,
        S_ERR
    } state_t;

    localparam logic [1:0]    ERR_OK    = 2'd0;
    localparam logic [1:0]    ERR_PIX   = 2'd1;
    localparam logic [1:0]    ERR_CNT   = 2'd2;
    localparam logic [1:0]    ERR_CODE  = 2'd3;
    localparam logic [AW-1:0] LAST_ADDR = AW'(NPIX - 1);
    // The wait counter holds the number of wait cycles already spent, so
    // the TIMEOUT-th wait cycle is the one where it reads TIMEOUT-1.
    localparam logic [7:0]    WAIT_LAST = 8'(TIMEOUT - 1);

    state_t        state;
    state_t        state_nxt;
    logic [AW-1:0] addr;
    logic          clr_second;
    logic          rd_q;
    logic [7:0]    wcnt;
    logic [1:0]    err_q;

    logic          pix_bad;
    logic          wait_exp;
    logic          err_clr;
    logic          err_set;
    logic [1:0]    err_nxt;
    logic          cap_cnt;
    logic          cap_code;

    // Pixel pipe: the ROM answers one cycle after the read, and that data
    // goes straight to the core in the same cycle, so the only stage is
    // the registered copy of the read strobe.
    assign pix_bad    = rd_q && ((rom_q == 8'd0) || (rom_q > 8'd6));
    assign gray_valid = rd_q && !pix_bad;
    assign gray_data  = rd_q ? rom_q : 8'd0;

    assign wait_exp   = (wcnt == WAIT_LAST);
    assign rom_addr   = addr;
    assign err        = err_q;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        busy      = 1'b1;
        done      = 1'b0;
        core_rst  = 1'b0;
        rom_rd    = 1'b0;
        err_clr   = 1'b0;
        err_set   = 1'b0;
        err_nxt   = ERR_OK;
        cap_cnt   = 1'b0;
        cap_code  = 1'b0;

        case (state)
            S_IDLE: begin
                busy     = 1'b0;
                core_rst = 1'b1;
                if (start) begin
                    err_clr   = 1'b1;
                    state_nxt = S_CLR;
                end
            end

            S_CLR: begin
                core_rst = 1'b1;
                if (clr_second) begin
                    state_nxt = S_FETCH;
                end
            end

            S_FETCH: begin
                rom_rd = 1'b1;
                if (pix_bad) begin
                    err_set   = 1'b1;
                    err_nxt   = ERR_PIX;
                    state_nxt = S_ERR;
                end else if (addr == LAST_ADDR) begin
                    state_nxt = S_WAIT_CNT;
                end
            end

            S_WAIT_CNT: begin
                // The first cycle here still carries the final pixel, so a
                // bad value there is reported as a pixel error.
                if (pix_bad) begin
                    err_set   = 1'b1;
                    err_nxt   = ERR_PIX;
                    state_nxt = S_ERR;
                end else if (CNT_valid) begin
                    cap_cnt   = 1'b1;
                    state_nxt = S_WAIT_CODE;
                end else if (wait_exp) begin
                    err_set   = 1'b1;
                    err_nxt   = ERR_CNT;
                    state_nxt = S_ERR;
                end
            end

            S_WAIT_CODE: begin
                if (code_valid) begin
                    cap_code  = 1'b1;
                    state_nxt = S_DONE;
                end else if (wait_exp) begin
                    err_set   = 1'b1;
                    err_nxt   = ERR_CODE;
                    state_nxt = S_ERR;
                end
            end

            S_DONE: begin
                done      = 1'b1;
                state_nxt = S_IDLE;
            end

            S_ERR: begin
                done      = 1'b1;
                core_rst  = 1'b1;
                state_nxt = S_IDLE;
            end

            default: begin
                state_nxt = S_IDLE;
            end
        endcase
    end

    // Read address walks 0..NPIX-1 while fetching and rests at 0 otherwise.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            addr <= '0;
        end else if ((state == S_FETCH) && (state_nxt == S_FETCH)) begin
            addr <= addr + 1'b1;
        end else begin
            addr <= '0;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            clr_second <= 1'b0;
        end else if (state == S_CLR) begin
            clr_second <= ~clr_second;
        end else begin
            clr_second <= 1'b0;
        end
    end

    // A bad pixel kills the strobe of the read already in flight so nothing
    // more reaches the core after the error.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rd_q <= 1'b0;
        end else begin
            rd_q <= rom_rd && !pix_bad;
        end
    end

    // Cleared on every state change, so each wait state starts from zero.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wcnt <= 8'd0;
        end else if (state_nxt != state) begin
            wcnt <= 8'd0;
        end else if (wcnt != 8'hFF) begin
            wcnt <= wcnt + 8'd1;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            err_q <= ERR_OK;
        end else if (err_clr) begin
            err_q <= ERR_OK;
        end else if (err_set) begin
            err_q <= err_nxt;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt_tbl <= 48'd0;
        end else if (cap_cnt) begin
            cnt_tbl <= cnt_in;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            hc_tbl <= 48'd0;
            m_tbl  <= 48'd0;
        end else if (cap_code) begin
            hc_tbl <= hc_in;
            m_tbl  <= m_in;
        end
    end

endmodule

// File: tb/tb_huffman_seq.sv
// tb_huffman_seq
//
// Bench for huffman_seq: a synchronous ROM model, a behavioural core model
// with randomised response delays, and a reference built from the ROM
// contents (expected pixel stream, histogram, error code, done timing).

module tb_huffman_seq;

    localparam int NPIX    = 100;
    localparam int AW      = 7;
    localparam int TIMEOUT = 255;

    localparam logic [47:0] HC_KEY = 48'h5A5A_5A5A_5A5A;
    localparam logic [47:0] M_KEY  = 48'h0101_0101_0101;

    logic          clk;
    logic          reset;
    logic          start;
    logic          busy;
    logic          done;
    logic [1:0]    err;
    logic          rom_rd;
    logic [AW-1:0] rom_addr;
    logic [7:0]    rom_q;
    logic          core_rst;
    logic          gray_valid;
    logic [7:0]    gray_data;
    logic          CNT_valid;
    logic          code_valid;
    logic [47:0]   cnt_in;
    logic [47:0]   hc_in;
    logic [47:0]   m_in;
    logic [47:0]   cnt_tbl;
    logic [47:0]   hc_tbl;
    logic [47:0]   m_tbl;

    huffman_seq #(.NPIX(NPIX), .AW(AW), .TIMEOUT(TIMEOUT)) dut (
        .clk        (clk),
        .reset      (reset),
        .start      (start),
        .busy       (busy),
        .done       (done),
        .err        (err),
        .rom_rd     (rom_rd),
        .rom_addr   (rom_addr),
        .rom_q      (rom_q),
        .core_rst   (core_rst),
        .gray_valid (gray_valid),
        .gray_data  (gray_data),
        .CNT_valid  (CNT_valid),
        .code_valid (code_valid),
        .cnt_in     (cnt_in),
        .hc_in      (hc_in),
        .m_in       (m_in),
        .cnt_tbl    (cnt_tbl),
        .hc_tbl     (hc_tbl),
        .m_tbl      (m_tbl)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_vec = 0;
    int n_mis = 0;

    task automatic check_val(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_mis++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
        end
    endtask

    // ---------------- environment knobs (written only by the main block)
    logic [7:0] rom [0:127];
    int  cnt_dly    = 2;
    int  code_dly   = 4;
    bit  cnt_never  = 1'b0;
    bit  code_never = 1'b0;

    // ---------------- ROM: data appears the cycle after the read
    initial begin : rom_model
        logic          s_rd;
        logic [AW-1:0] s_a;
        rom_q = 8'h00;
        forever begin
            @(negedge clk);
            s_rd = rom_rd;
            s_a  = rom_addr;
            @(posedge clk);
            #1;
            rom_q = s_rd ? rom[s_a] : 8'hEE;
        end
    end

    // ---------------- behavioural core
    initial begin : core_model
        logic        s_rst;
        logic        s_gv;
        logic [7:0]  s_gd;
        logic [47:0] hpk;
        int          npx;
        int          ph;
        int          cdown;
        CNT_valid  = 1'b0;
        code_valid = 1'b0;
        cnt_in     = 48'd0;
        hc_in      = 48'd0;
        m_in       = 48'd0;
        hpk        = 48'd0;
        npx        = 0;
        ph         = 0;
        cdown      = 0;
        forever begin
            @(negedge clk);
            s_rst = core_rst;
            s_gv  = gray_valid;
            s_gd  = gray_data;
            @(posedge clk);
            #1;
            CNT_valid = 1'b0;
            cnt_in    = 48'({$urandom(), $urandom()});
            if (s_rst) begin
                hpk        = 48'd0;
                npx        = 0;
                ph         = 0;
                code_valid = 1'b0;
            end else begin
                case (ph)
                    0: if (s_gv) begin
                        if (s_gd >= 8'd1 && s_gd <= 8'd6)
                            hpk[8*int'(s_gd)-8 +: 8] = hpk[8*int'(s_gd)-8 +: 8] + 8'd1;
                        npx++;
                        if (npx == NPIX) begin
                            ph    = 1;
                            cdown = cnt_dly;
                        end
                    end
                    1: if (!cnt_never) begin
                        if (cdown == 0) begin
                            CNT_valid = 1'b1;
                            cnt_in    = hpk;
                            ph        = 2;
                            cdown     = code_dly;
                        end else begin
                            cdown--;
                        end
                    end
                    2: if (!code_never) begin
                        if (cdown == 0) begin
                            code_valid = 1'b1;
                            ph         = 3;
                        end else begin
                            cdown--;
                        end
                    end
                    default: ;
                endcase
            end
            if (code_valid) begin
                hc_in = hpk ^ HC_KEY;
                m_in  = hpk + M_KEY;
            end else begin
                hc_in = 48'({$urandom(), $urandom()});
                m_in  = 48'({$urandom(), $urandom()});
            end
        end
    end

    // ---------------- monitor (sole writer of its variables)
    int         gv_cnt   = 0;
    int         gv_rise  = -1;
    int         gv_last  = -1;
    int         done_cnt = 0;
    int         done_cyc = -1;
    int         cv_cyc   = -1;
    logic [1:0] err_at_done;
    logic       crst_at_done;
    logic [7:0] gv_q [$];

    initial begin : monitor
        logic prev_gv;
        prev_gv = 1'b0;
        forever begin
            @(negedge clk);
            if (gray_valid) begin
                if (!prev_gv) gv_rise = cyc;
                gv_last = cyc;
                gv_cnt++;
                gv_q.push_back(gray_data);
            end
            prev_gv = gray_valid;
            if (CNT_valid) cv_cyc = cyc;
            if (done) begin
                done_cnt++;
                done_cyc     = cyc;
                err_at_done  = err;
                crst_at_done = core_rst;
            end
        end
    end

    // ---------------- reference helpers
    logic [47:0] exp_cnt = 48'd0;
    logic [47:0] exp_hc  = 48'd0;
    logic [47:0] exp_m   = 48'd0;

    function automatic logic [47:0] ref_hist();
        int c [1:6];
        int v;
        logic [47:0] r;
        for (int s = 1; s <= 6; s++) c[s] = 0;
        for (int i = 0; i < NPIX; i++) begin
            v = int'(rom[i]);
            if (v >= 1 && v <= 6) c[v]++;
        end
        r = 48'd0;
        for (int s = 1; s <= 6; s++) r = r | (48'(c[s]) << (8 * (s - 1)));
        return r;
    endfunction

    task automatic fill_random();
        for (int i = 0; i < 128; i++) rom[i] = 8'($urandom_range(1, 6));
    endtask

    task automatic check_reset_vals(input string p);
        check_val({p, "_busy"},       64'(busy),       64'd0);
        check_val({p, "_done"},       64'(done),       64'd0);
        check_val({p, "_err"},        64'(err),        64'd0);
        check_val({p, "_rom_rd"},     64'(rom_rd),     64'd0);
        check_val({p, "_rom_addr"},   64'(rom_addr),   64'd0);
        check_val({p, "_gray_valid"}, 64'(gray_valid), 64'd0);
        check_val({p, "_gray_data"},  64'(gray_data),  64'd0);
        check_val({p, "_core_rst"},   64'(core_rst),   64'd1);
        check_val({p, "_cnt_tbl"},    64'(cnt_tbl),    64'd0);
        check_val({p, "_hc_tbl"},     64'(hc_tbl),     64'd0);
        check_val({p, "_m_tbl"},      64'(m_tbl),      64'd0);
    endtask

    // kind: 0 good frame, 1 illegal pixel at bad_addr, 2 CNT timeout, 3 CODE timeout
    task automatic run_frame(input string nm, input int kind, input int bad_addr, input bit poke);
        int t;
        int d0;
        int q0;
        int exp_n;
        int got_n;
        int nbad;
        bit seen;
        logic [47:0] h;

        cnt_never  = (kind == 2);
        code_never = (kind == 3);
        cnt_dly    = $urandom_range(0, 12);
        code_dly   = $urandom_range(0, 12);
        exp_n      = (kind == 1) ? bad_addr : NPIX;
        h          = ref_hist();

        d0 = done_cnt;
        q0 = gv_q.size();
        @(posedge clk);
        #1;
        start = 1'b1;
        t     = cyc;
        @(posedge clk);
        #1;
        start = 1'b0;
        check_val({nm, "_busy_rise"}, 64'(busy), 64'd1);
        check_val({nm, "_err_clr"},   64'(err),  64'd0);

        if (poke) begin
            repeat (20) @(posedge clk);
            #1;
            start = 1'b1;
            @(posedge clk);
            #1;
            start = 1'b0;
        end

        seen = 1'b0;
        for (int i = 0; i < 2000 && !seen; i++) begin
            @(posedge clk);
            if (done_cnt != d0) seen = 1'b1;
        end
        check_val({nm, "_done_seen"}, 64'(seen), 64'd1);
        #1;
        check_val({nm, "_busy_fall"}, 64'(busy), 64'd0);

        check_val({nm, "_err"},      64'(err_at_done),  64'(kind));
        check_val({nm, "_core_rst"}, 64'(crst_at_done), (kind == 0) ? 64'd0 : 64'd1);
        check_val({nm, "_gv_count"}, 64'(gv_q.size() - q0), 64'(exp_n));
        check_val({nm, "_gv_first"}, 64'(gv_rise), 64'(t + 4));
        check_val({nm, "_gv_last"},  64'(gv_last), 64'(t + 3 + exp_n));

        got_n = gv_q.size() - q0;
        nbad  = 0;
        for (int i = 0; i < got_n && i < exp_n; i++)
            if (gv_q[q0 + i] !== rom[i]) nbad++;
        check_val({nm, "_stream"}, 64'(nbad), 64'd0);

        if (kind == 1) check_val({nm, "_done_cyc"}, 64'(done_cyc), 64'(t + 5 + bad_addr));
        if (kind == 2) check_val({nm, "_done_cyc"}, 64'(done_cyc), 64'(t + NPIX + 3 + TIMEOUT));
        if (kind == 3) check_val({nm, "_done_cyc"}, 64'(done_cyc), 64'(cv_cyc + 1 + TIMEOUT));

        if (kind == 0 || kind == 3) exp_cnt = h;
        if (kind == 0) begin
            exp_hc = h ^ HC_KEY;
            exp_m  = h + M_KEY;
        end
        check_val({nm, "_cnt_tbl"}, 64'(cnt_tbl), 64'(exp_cnt));
        check_val({nm, "_hc_tbl"},  64'(hc_tbl),  64'(exp_hc));
        check_val({nm, "_m_tbl"},   64'(m_tbl),   64'(exp_m));

        repeat (5) @(posedge clk);
        #1;
        check_val({nm, "_one_done"}, 64'(done_cnt - d0), 64'd1);
    endtask

    initial begin : main
        int k;
        int nom [6];
        nom = '{10, 20, 30, 15, 15, 10};
        reset = 1'b1;
        start = 1'b0;
        fill_random();

        repeat (3) @(posedge clk);
        #1;
        check_reset_vals("por");
        reset = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check_val("idle_busy",     64'(busy),     64'd0);
        check_val("idle_core_rst", 64'(core_rst), 64'd1);

        // nominal frame with the documented symbol mix
        k = 0;
        for (int s = 0; s < 6; s++)
            for (int j = 0; j < nom[s]; j++) begin
                rom[k] = 8'(s + 1);
                k++;
            end
        run_frame("nom", 0, 0, 1'b0);
        check_val("nom_cnt_const", 64'(cnt_tbl), 64'h0A0F0F1E140A);

        // illegal pixels: zero, then a value above 6
        fill_random();
        rom[37] = 8'd0;
        run_frame("ill0", 1, 37, 1'b0);
        fill_random();
        rom[80] = 8'd9;
        run_frame("ill9", 1, 80, 1'b0);

        fill_random();
        run_frame("cnt_to", 2, 0, 1'b0);

        fill_random();
        run_frame("code_to", 3, 0, 1'b0);
        fill_random();
        run_frame("recover", 0, 0, 1'b0);

        fill_random();
        run_frame("poke", 0, 0, 1'b1);

        // reset in the middle of a fetch
        fill_random();
        @(posedge clk);
        #1;
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        for (int i = 0; i < 300 && rom_addr != 7'd50; i++) @(negedge clk);
        check_val("mid_reach", 64'(rom_addr), 64'd50);
        #1;
        reset = 1'b1;
        #1;
        check_reset_vals("mid");
        exp_cnt = 48'd0;
        exp_hc  = 48'd0;
        exp_m   = 48'd0;
        @(posedge clk);
        #2;
        reset = 1'b0;
        fill_random();
        run_frame("post_rst", 0, 0, 1'b0);

        for (int r = 0; r < 3; r++) begin
            fill_random();
            run_frame($sformatf("rnd%0d", r), 0, 0, 1'b0);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_mis);
        $finish;
    end

endmodule
